// File: rtl/wb_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage_if
// Brief    : MEM->WB pipeline handshake and payload bundle.
// Revision : 1.0
// ============================================================================
interface wb_stage_if;
  logic        mem_to_wb_valid;
  logic        wb_ready;
  logic        mem_mem_rsignal;
  logic [3:0]  mem_mem_re;
  logic [31:0] mem_alu_res;
  logic [4:0]  mem_rf_waddr;
  logic        mem_rf_we;
  logic [31:0] mem_pc;
  logic [31:0] mem_inst;

  modport master (
    output mem_to_wb_valid, mem_mem_rsignal, mem_mem_re, mem_alu_res,
           mem_rf_waddr, mem_rf_we, mem_pc, mem_inst,
    input  wb_ready
  );

  modport slave (
    input  mem_to_wb_valid, mem_mem_rsignal, mem_mem_re, mem_alu_res,
           mem_rf_waddr, mem_rf_we, mem_pc, mem_inst,
    output wb_ready
  );
endinterface
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage
// Brief    : Writeback stage: load response wait/align, regfile write, trace.
// Revision : 1.0
// ============================================================================
module wb_stage #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  wb_stage_if.slave   up,
  input  logic [31:0] data_sram_rdata,
  input  logic        data_sram_data_ok,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        wb_load_pending,
  output logic        wb_load_timeout,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_we,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
);

  localparam logic [7:0] c_max_wait = 8'(MAX_WAIT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        valid_q, valid_d;
  logic        ld_q, ld_d;
  logic [3:0]  re_q, re_d;
  logic [31:0] alu_q, alu_d;
  logic [4:0]  waddr_q, waddr_d;
  logic        we_q, we_d;
  logic [31:0] pc_q, pc_d;
  logic        uns_q, uns_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_data_q, buf_data_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        timeout_q, timeout_d;
  logic [31:0] dbg_pc_q, dbg_pc_d;

  logic        ready_go;
  logic        ready;
  logic        retire;
  logic [31:0] src;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_data;

  always_comb begin
    ready_go = ~ld_q | data_sram_data_ok | buf_valid_q;
    ready    = ~valid_q | ready_go;
    retire   = valid_q & ready_go;
  end

  // A buffered response wins over the live bus so a late retire still sees its data.
  always_comb begin
    src    = buf_valid_q ? buf_data_q : data_sram_rdata;
    byte_v = src[{alu_q[1:0], 3'b000} +: 8];
    half_v = src[{alu_q[1], 4'b0000} +: 16];
    case (re_q)
      4'b0001, 4'b0010, 4'b0100, 4'b1000:
        load_data = uns_q ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
      4'b0011, 4'b1100:
        load_data = uns_q ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
      default:
        load_data = src;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    ld_d        = ld_q;
    re_d        = re_q;
    alu_d       = alu_q;
    waddr_d     = waddr_q;
    we_d        = we_q;
    pc_d        = pc_q;
    uns_d       = uns_q;
    buf_valid_d = buf_valid_q;
    buf_data_d  = buf_data_q;
    wait_cnt_d  = wait_cnt_q;
    dbg_pc_d    = dbg_pc_q;

    if (ready) begin
      valid_d = up.mem_to_wb_valid;
      if (up.mem_to_wb_valid) begin
        ld_d    = up.mem_mem_rsignal;
        re_d    = up.mem_mem_re;
        alu_d   = up.mem_alu_res;
        waddr_d = up.mem_rf_waddr;
        we_d    = up.mem_rf_we;
        pc_d    = up.mem_pc;
        uns_d   = up.mem_inst[25];
        state_d = up.mem_mem_rsignal ? S_WAIT : S_DONE;
      end else begin
        state_d = S_IDLE;
      end
    end

    if (retire) begin
      buf_valid_d = 1'b0;
      dbg_pc_d    = pc_q;
    end else if (valid_q && ld_q && data_sram_data_ok) begin
      buf_valid_d = 1'b1;
      buf_data_d  = data_sram_rdata;
    end

    if (retire) begin
      wait_cnt_d = 8'd0;
    end else if (state_q == S_WAIT && !data_sram_data_ok && wait_cnt_q != 8'hff) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end

    timeout_d = timeout_q | (wait_cnt_d >= c_max_wait);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      valid_q     <= 1'b0;
      ld_q        <= 1'b0;
      re_q        <= 4'b0;
      alu_q       <= 32'b0;
      waddr_q     <= 5'b0;
      we_q        <= 1'b0;
      pc_q        <= 32'b0;
      uns_q       <= 1'b0;
      buf_valid_q <= 1'b0;
      buf_data_q  <= 32'b0;
      wait_cnt_q  <= 8'b0;
      timeout_q   <= 1'b0;
      dbg_pc_q    <= 32'b0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      ld_q        <= ld_d;
      re_q        <= re_d;
      alu_q       <= alu_d;
      waddr_q     <= waddr_d;
      we_q        <= we_d;
      pc_q        <= pc_d;
      uns_q       <= uns_d;
      buf_valid_q <= buf_valid_d;
      buf_data_q  <= buf_data_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
      dbg_pc_q    <= dbg_pc_d;
    end
  end

  // Address and data stay driven when idle so forwarding can compare them.
  always_comb begin
    up.wb_ready       = ready;
    rf_we             = retire & we_q;
    rf_waddr          = waddr_q;
    rf_wdata          = ld_q ? load_data : alu_q;
    wb_load_pending   = valid_q & ld_q & ~ready_go;
    wb_load_timeout   = timeout_q;
    debug_wb_pc       = retire ? pc_q : dbg_pc_q;
    debug_wb_rf_we    = {4{rf_we}};
    debug_wb_rf_wnum  = rf_waddr;
    debug_wb_rf_wdata = rf_wdata;
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_stage
// Brief    : Vector table, corner sequences and random stream for wb_stage.
// Revision : 1.0
// ============================================================================
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_sram_rdata;
  logic        data_sram_data_ok;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        wb_load_pending;
  logic        wb_load_timeout;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_we;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;

  int n_cmp = 0;
  int n_bad = 0;

  wb_stage_if u_if ();

  wb_stage #(.MAX_WAIT(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .up                (u_if),
    .data_sram_rdata   (data_sram_rdata),
    .data_sram_data_ok (data_sram_data_ok),
    .rf_we             (rf_we),
    .rf_waddr          (rf_waddr),
    .rf_wdata          (rf_wdata),
    .wb_load_pending   (wb_load_pending),
    .wb_load_timeout   (wb_load_timeout),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_we    (debug_wb_rf_we),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic [3:0]  re;
    logic [31:0] alu;
    logic        uns;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] rdata;
    logic [31:0] exp_wdata;
  } vec_t;

  typedef struct {
    logic        ld;
    logic [3:0]  re;
    logic [31:0] alu;
    logic [4:0]  waddr;
    logic        we;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] rdata;
    int          delay;
  } instr_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input instr_t t);
    u_if.mem_to_wb_valid = v;
    u_if.mem_mem_rsignal = t.ld;
    u_if.mem_mem_re      = t.re;
    u_if.mem_alu_res     = t.alu;
    u_if.mem_rf_waddr    = t.waddr;
    u_if.mem_rf_we       = t.we;
    u_if.mem_pc          = t.pc;
    u_if.mem_inst        = t.inst;
  endtask

  task automatic chk_ret(input string name, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [31:0] pc);
    chk({name, ".rf_we"}, 32'(rf_we), 32'(we));
    chk({name, ".rf_waddr"}, 32'(rf_waddr), 32'(wa));
    chk({name, ".rf_wdata"}, rf_wdata, wd);
    chk({name, ".dbg_we"}, 32'(debug_wb_rf_we), we ? 32'hf : 32'h0);
    chk({name, ".dbg_pc"}, debug_wb_pc, pc);
    chk({name, ".dbg_wnum"}, 32'(debug_wb_rf_wnum), 32'(wa));
    chk({name, ".dbg_wdata"}, debug_wb_rf_wdata, wd);
  endtask

  task automatic chk_reset_state(input string name);
    chk({name, ".rf_we"}, 32'(rf_we), 0);
    chk({name, ".rf_waddr"}, 32'(rf_waddr), 0);
    chk({name, ".rf_wdata"}, rf_wdata, 0);
    chk({name, ".pending"}, 32'(wb_load_pending), 0);
    chk({name, ".timeout"}, 32'(wb_load_timeout), 0);
    chk({name, ".dbg_pc"}, debug_wb_pc, 0);
    chk({name, ".dbg_we"}, 32'(debug_wb_rf_we), 0);
    chk({name, ".wb_ready"}, 32'(u_if.wb_ready), 1);
  endtask

  // Load result derived from size/offset arithmetic.
  function automatic logic [31:0] ref_load(input logic [3:0] re, input logic [1:0] off,
                                           input logic [31:0] d, input logic uns);
    logic [31:0] v;
    int          sh;
    if ($countones(re) == 1) begin
      sh = 8 * int'(off);
      v  = (d >> sh) & 32'hff;
      if (!uns && v[7]) v = v | 32'hffffff00;
    end else if (re == 4'b0011 || re == 4'b1100) begin
      sh = 16 * int'(off[1]);
      v  = (d >> sh) & 32'hffff;
      if (!uns && v[15]) v = v | 32'hffff0000;
    end else begin
      v = d;
    end
    return v;
  endfunction

  function automatic instr_t mk(input logic ld, input logic [3:0] re, input logic [31:0] alu,
                                input logic [4:0] wa, input logic we, input logic [31:0] pc,
                                input logic uns);
    instr_t t;
    t.ld = ld; t.re = re; t.alu = alu; t.waddr = wa; t.we = we; t.pc = pc;
    t.inst = {6'b0, uns, 25'b0}; t.rdata = 32'h0; t.delay = 0;
    return t;
  endfunction

  vec_t   vec [8];
  instr_t t, h, upi, none;
  logic   hold, up_v, exp_ready, exp_ret;
  logic [31:0] last_pc, exp_wd;
  int     wcyc;
  logic [1:0] off;
  int     sz;

  initial begin
    vec[0] = '{1'b0, 4'h0, 32'h12345678, 1'b0, 1'b1, 5'd5,  32'h0,        32'h12345678};
    vec[1] = '{1'b1, 4'h8, 32'h00000103, 1'b0, 1'b1, 5'd6,  32'h80FF0000, 32'hFFFFFF80};
    vec[2] = '{1'b1, 4'hC, 32'h00000202, 1'b1, 1'b1, 5'd7,  32'h80010000, 32'h00008001};
    vec[3] = '{1'b1, 4'h2, 32'h00000301, 1'b1, 1'b1, 5'd8,  32'h1234A578, 32'h000000A5};
    vec[4] = '{1'b1, 4'h3, 32'h00000400, 1'b0, 1'b1, 5'd9,  32'h00008001, 32'hFFFF8001};
    vec[5] = '{1'b1, 4'hF, 32'h00000500, 1'b0, 1'b1, 5'd10, 32'hDEADBEEF, 32'hDEADBEEF};
    vec[6] = '{1'b1, 4'h5, 32'h00000600, 1'b0, 1'b1, 5'd11, 32'h11223344, 32'h11223344};
    vec[7] = '{1'b0, 4'h0, 32'hCAFE0000, 1'b0, 1'b0, 5'd12, 32'h0,        32'hCAFE0000};

    none = mk(1'b0, 4'h0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0);
    rst = 1'b1;
    data_sram_rdata = 32'h0;
    data_sram_data_ok = 1'b0;
    drive(1'b0, none);
    step(); step();
    chk_reset_state("reset");
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      t = mk(vec[i].ld, vec[i].re, vec[i].alu, vec[i].waddr, vec[i].we,
             32'h1000 + 32'(4 * i), vec[i].uns);
      drive(1'b1, t);
      step();
      u_if.mem_to_wb_valid = 1'b0;
      data_sram_data_ok = vec[i].ld;
      data_sram_rdata   = vec[i].rdata;
      #1;
      chk($sformatf("vec%0d.ready", i), 32'(u_if.wb_ready), 1);
      chk($sformatf("vec%0d.pending", i), 32'(wb_load_pending), 0);
      chk_ret($sformatf("vec%0d", i), vec[i].we, vec[i].waddr, vec[i].exp_wdata, t.pc);
      step();
      data_sram_data_ok = 1'b0;
      #1;
      chk($sformatf("vec%0d.idle_we", i), 32'(rf_we), 0);
      chk($sformatf("vec%0d.hold_pc", i), debug_wb_pc, t.pc);
    end

    // ld.b with three stall cycles before the response
    t = mk(1'b1, 4'h8, 32'h00002003, 5'd3, 1'b1, 32'h2000, 1'b0);
    drive(1'b1, t);
    step();
    u_if.mem_to_wb_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("ldb.stall%0d.pending", k), 32'(wb_load_pending), 1);
      chk($sformatf("ldb.stall%0d.ready", k), 32'(u_if.wb_ready), 0);
      chk($sformatf("ldb.stall%0d.we", k), 32'(rf_we), 0);
      step();
    end
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h80FF0000;
    #1;
    chk("ldb.ready", 32'(u_if.wb_ready), 1);
    chk("ldb.pending", 32'(wb_load_pending), 0);
    chk_ret("ldb", 1'b1, 5'd3, 32'hFFFFFF80, 32'h2000);
    step();
    data_sram_data_ok = 1'b0;
    #1;
    chk("ldb.after_we", 32'(rf_we), 0);
    chk("ldb.timeout", 32'(wb_load_timeout), 0);

    // Load stalls two cycles while an add waits upstream
    t = mk(1'b1, 4'hF, 32'h00003000, 5'd14, 1'b1, 32'h3000, 1'b0);
    drive(1'b1, t);
    step();
    t = mk(1'b0, 4'h0, 32'h00ABCDEF, 5'd15, 1'b1, 32'h3004, 1'b0);
    drive(1'b1, t);
    for (int k = 0; k < 2; k++) begin
      #1;
      chk($sformatf("b2b.stall%0d.ready", k), 32'(u_if.wb_ready), 0);
      chk($sformatf("b2b.stall%0d.we", k), 32'(rf_we), 0);
      step();
    end
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h55AA1234;
    #1;
    chk_ret("b2b.ld", 1'b1, 5'd14, 32'h55AA1234, 32'h3000);
    step();
    data_sram_data_ok = 1'b0;
    u_if.mem_to_wb_valid = 1'b0;
    #1;
    chk_ret("b2b.add", 1'b1, 5'd15, 32'h00ABCDEF, 32'h3004);
    step();
    #1;
    chk("b2b.once", 32'(rf_we), 0);

    // Response never arrives: sticky timeout, then reset mid-wait
    t = mk(1'b1, 4'h1, 32'h00004000, 5'd20, 1'b1, 32'h4000, 1'b0);
    drive(1'b1, t);
    step();
    u_if.mem_to_wb_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk($sformatf("tmo.k%0d", k), 32'(wb_load_timeout), (k >= 4) ? 32'd1 : 32'd0);
      chk($sformatf("tmo.k%0d.pending", k), 32'(wb_load_pending), 1);
    end
    rst = 1'b1;
    step();
    chk_reset_state("midrst");
    rst = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hFFFFFFFF;
    #1;
    chk("late_ok.we", 32'(rf_we), 0);
    step();
    data_sram_data_ok = 1'b0;
    #1;
    chk("late_ok.we2", 32'(rf_we), 0);
    chk("late_ok.tmo", 32'(wb_load_timeout), 0);

    // Random stream against a transaction-level model
    hold = 1'b0; up_v = 1'b0; wcyc = 0; last_pc = 32'h0;
    h = none; upi = none;
    for (int c = 0; c < 600; c++) begin
      if (!up_v && $urandom_range(0, 2) != 0) begin
        upi.ld = 1'($urandom_range(0, 1));
        sz = $urandom_range(0, 3);
        off = 2'($urandom_range(0, 3));
        case (sz)
          0: upi.re = 4'b0001 << off;
          1: begin off = {off[1], 1'b0}; upi.re = 4'b0011 << off; end
          2: begin off = 2'b00; upi.re = 4'hF; end
          default: upi.re = 4'($urandom_range(0, 15));
        endcase
        upi.alu = $urandom();
        upi.alu[1:0] = off;
        upi.waddr = 5'($urandom_range(0, 31));
        upi.we = 1'($urandom_range(0, 3) != 0);
        upi.pc = $urandom();
        upi.inst = $urandom();
        upi.rdata = $urandom();
        upi.delay = upi.ld ? $urandom_range(0, 3) : 0;
        up_v = 1'b1;
      end
      drive(up_v, upi);
      if (hold && h.ld) begin
        data_sram_data_ok = (wcyc == h.delay);
        data_sram_rdata   = (wcyc == h.delay) ? h.rdata : $urandom();
      end else begin
        data_sram_data_ok = ($urandom_range(0, 5) == 0);
        data_sram_rdata   = $urandom();
      end
      #1;
      exp_ready = !hold || !h.ld || (wcyc == h.delay);
      exp_ret   = hold && exp_ready;
      if (exp_ret) last_pc = h.pc;
      chk("rnd.ready", 32'(u_if.wb_ready), 32'(exp_ready));
      chk("rnd.pending", 32'(wb_load_pending), 32'(hold && !exp_ready));
      chk("rnd.rf_we", 32'(rf_we), 32'(exp_ret && h.we));
      chk("rnd.timeout", 32'(wb_load_timeout), 0);
      chk("rnd.dbg_pc", debug_wb_pc, last_pc);
      if (hold) begin
        exp_wd = h.ld ? ref_load(h.re, h.alu[1:0], h.rdata, h.inst[25]) : h.alu;
        chk("rnd.waddr", 32'(rf_waddr), 32'(h.waddr));
        if (exp_ret) chk("rnd.wdata", rf_wdata, exp_wd);
      end
      step();
      if (exp_ready) begin
        hold = up_v;
        if (up_v) h = upi;
        up_v = 1'b0;
        wcyc = 0;
      end else begin
        wcyc++;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
